// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 datapath constants and the ID/EX control-word field map
package mips_pkg;
  localparam int CTRL_W = 12;
  localparam int REG_WRITE = 0;
  localparam int MEM_READ = 1;
  localparam int MEM_WRITE = 2;
  localparam int ALU_SRC = 3;
  localparam int ALU_OP_LO = 4;
  localparam int ALU_OP_HI = 7;
  localparam int MEM_TO_REG = 8;
  localparam int REG_DST = 9;
  localparam int BRANCH = 10;
  localparam int JUMP = 11;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline register with async reset, clear (flush) over hold (stall) over load
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clear ? '0 : hold ? q_q : d;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall hold, flush bubble and saturating event counters
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [DATA_W-1:0]     in_rs_data,
  input  logic [DATA_W-1:0]     in_rt_data,
  input  logic [DATA_W-1:0]     in_imm_ext,
  input  logic [REG_ADDR_W-1:0] in_rs_addr,
  input  logic [REG_ADDR_W-1:0] in_rt_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [4:0]            in_shamt,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_pc_plus4,
  output logic [DATA_W-1:0]     out_rs_data,
  output logic [DATA_W-1:0]     out_rt_data,
  output logic [DATA_W-1:0]     out_imm_ext,
  output logic [REG_ADDR_W-1:0] out_rs_addr,
  output logic [REG_ADDR_W-1:0] out_rt_addr,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [4:0]            out_shamt,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic                  out_ex_mem_read,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int CW = 1 + CTRL_W;
  localparam int DW = 4 * DATA_W;
  localparam int AW = 3 * REG_ADDR_W + 5;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [CTRL_W-1:0] ctrl_load;
  // An invalid instruction must carry no side effects downstream, so its control word is squashed
  assign ctrl_load = in_valid ? in_ctrl : CTRL_NOP;
  pipe_field_reg #(.W(CW)) u_ctrl (
    .clk(clk), .rst(rst), .hold(stall), .clear(flush),
    .d({in_valid, ctrl_load}), .q({out_valid, out_ctrl})
  );
  pipe_field_reg #(.W(DW)) u_data (
    .clk(clk), .rst(rst), .hold(stall), .clear(flush),
    .d({in_pc_plus4, in_rs_data, in_rt_data, in_imm_ext}),
    .q({out_pc_plus4, out_rs_data, out_rt_data, out_imm_ext})
  );
  pipe_field_reg #(.W(AW)) u_addr (
    .clk(clk), .rst(rst), .hold(stall), .clear(flush),
    .d({in_rs_addr, in_rt_addr, in_rd_addr, in_shamt}),
    .q({out_rs_addr, out_rt_addr, out_rd_addr, out_shamt})
  );
  assign out_ex_mem_read = out_ctrl[MEM_READ] & out_valid;
  always_comb begin
    stall_cnt_d = (stall && !flush && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven vectors with a scoreboard queue of expected register contents
module tb_id_ex_pipe_reg;
  logic clk = 0, rst = 1, stall = 0, flush = 0, in_valid = 0;
  logic [31:0] in_pc_plus4 = 0, in_rs_data = 0, in_rt_data = 0, in_imm_ext = 0;
  logic [4:0] in_rs_addr = 0, in_rt_addr = 0, in_rd_addr = 0, in_shamt = 0;
  logic [11:0] in_ctrl = 0;
  logic out_valid, out_ex_mem_read;
  logic [31:0] out_pc_plus4, out_rs_data, out_rt_data, out_imm_ext;
  logic [4:0] out_rs_addr, out_rt_addr, out_rd_addr, out_shamt;
  logic [11:0] out_ctrl;
  logic [15:0] stall_cnt, flush_cnt;
  int total = 0, passed = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc_plus4(in_pc_plus4), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm_ext(in_imm_ext), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_shamt(in_shamt), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_pc_plus4(out_pc_plus4), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_imm_ext(out_imm_ext), .out_rs_addr(out_rs_addr),
    .out_rt_addr(out_rt_addr), .out_rd_addr(out_rd_addr), .out_shamt(out_shamt),
    .out_ctrl(out_ctrl), .out_ex_mem_read(out_ex_mem_read),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush, valid;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0] rsa, rta, rda, sh;
    logic [11:0] ctrl;
    logic e_valid, e_mrd;
    logic [11:0] e_ctrl;
  } vec_t;

  typedef struct {
    logic valid, mrd;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0] rsa, rta, rda, sh;
    logic [11:0] ctrl;
    logic [15:0] scnt, fcnt;
  } exp_t;

  exp_t m, sb[$];
  vec_t tbl[9];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic chk_all(input exp_t e);
    chk("out_valid", 64'(out_valid), 64'(e.valid));
    chk("out_pc_plus4", 64'(out_pc_plus4), 64'(e.pc));
    chk("out_rs_data", 64'(out_rs_data), 64'(e.rs));
    chk("out_rt_data", 64'(out_rt_data), 64'(e.rt));
    chk("out_imm_ext", 64'(out_imm_ext), 64'(e.imm));
    chk("out_rs_addr", 64'(out_rs_addr), 64'(e.rsa));
    chk("out_rt_addr", 64'(out_rt_addr), 64'(e.rta));
    chk("out_rd_addr", 64'(out_rd_addr), 64'(e.rda));
    chk("out_shamt", 64'(out_shamt), 64'(e.sh));
    chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
    chk("out_ex_mem_read", 64'(out_ex_mem_read), 64'(e.mrd));
    chk("stall_cnt", 64'(stall_cnt), 64'(e.scnt));
    chk("flush_cnt", 64'(flush_cnt), 64'(e.fcnt));
  endtask

  // Reference behaviour: flush beats stall beats load; invalid loads carry a zero control word
  task automatic drive(input vec_t v);
    exp_t n;
    stall = v.stall; flush = v.flush; in_valid = v.valid;
    in_pc_plus4 = v.pc; in_rs_data = v.rs; in_rt_data = v.rt; in_imm_ext = v.imm;
    in_rs_addr = v.rsa; in_rt_addr = v.rta; in_rd_addr = v.rda; in_shamt = v.sh;
    in_ctrl = v.ctrl;
    n = m;
    if (v.flush) begin
      n = '{default: '0};
      n.scnt = m.scnt;
      n.fcnt = (m.fcnt == 16'hFFFF) ? m.fcnt : m.fcnt + 1;
    end else if (v.stall) begin
      n.scnt = (m.scnt == 16'hFFFF) ? m.scnt : m.scnt + 1;
    end else begin
      n.valid = v.valid; n.pc = v.pc; n.rs = v.rs; n.rt = v.rt; n.imm = v.imm;
      n.rsa = v.rsa; n.rta = v.rta; n.rda = v.rda; n.sh = v.sh;
      n.ctrl = v.valid ? v.ctrl : 12'h000;
    end
    n.mrd = n.ctrl[1] & n.valid;
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    chk_all(sb.pop_front());
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic vl, input logic [31:0] rs,
                              input logic [11:0] c, input logic ev, input logic [11:0] ec, input logic em);
    vec_t v;
    v.stall = s; v.flush = f; v.valid = vl;
    v.pc = rs ^ 32'h0000_0404; v.rs = rs; v.rt = ~rs; v.imm = 32'hFFFF_8000 ^ {rs[15:0], 16'h0};
    v.rsa = rs[4:0]; v.rta = 5'd9; v.rda = rs[9:5]; v.sh = rs[14:10];
    v.ctrl = c; v.e_valid = ev; v.e_ctrl = ec; v.e_mrd = em;
    return v;
  endfunction

  initial begin
    vec_t v;
    m = '{default: '0};
    tbl[0] = mk(0, 0, 1, 32'h0000_0000, 12'h00B, 1, 12'h00B, 1);
    tbl[1] = mk(1, 0, 1, 32'h1234_5678, 12'hFFF, 1, 12'h00B, 1);
    tbl[2] = mk(1, 0, 0, 32'hCAFE_F00D, 12'h002, 1, 12'h00B, 1);
    tbl[3] = mk(1, 0, 1, 32'h0BAD_BEEF, 12'h7A5, 1, 12'h00B, 1);
    tbl[4] = mk(1, 1, 1, 32'h5555_AAAA, 12'h00B, 0, 12'h000, 0);
    tbl[5] = mk(0, 0, 0, 32'hDEAD_BEEF, 12'hFFF, 0, 12'h000, 0);
    tbl[6] = mk(0, 0, 1, 32'h1357_9BDF, 12'h002, 1, 12'h002, 1);
    tbl[7] = mk(0, 0, 1, 32'h2468_ACE0, 12'hFFD, 1, 12'hFFD, 0);
    tbl[8] = mk(0, 1, 0, 32'hFFFF_FFFF, 12'hFFF, 0, 12'h000, 0);
    #1;
    chk_all(m);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ctrl", i), 64'(out_ctrl), 64'(tbl[i].e_ctrl));
      chk($sformatf("tbl%0d_mrd", i), 64'(out_ex_mem_read), 64'(tbl[i].e_mrd));
    end
    chk("stall_cnt_after_table", 64'(stall_cnt), 64'd3);
    chk("flush_cnt_after_table", 64'(flush_cnt), 64'd2);
    drive(mk(0, 0, 1, 32'h89AB_CDEF, 12'h0F3, 1, 12'h0F3, 1));
    #2 rst = 1;
    #1;
    m = '{default: '0};
    chk_all(m);
    @(posedge clk); #1;
    v = mk(0, 0, 1, 32'h4444_3333, 12'h00B, 1, 12'h00B, 1);
    stall = 0; flush = 0; in_valid = 1; in_ctrl = 12'hFFF;
    @(posedge clk); #1;
    chk("held_in_reset_valid", 64'(out_valid), 64'd0);
    chk("held_in_reset_ctrl", 64'(out_ctrl), 64'd0);
    rst = 0;
    drive(v);
    chk("post_reset_load_imm", 64'(out_imm_ext), 64'(v.imm));
    rst = 1; #1; rst = 0;
    m = '{default: '0};
    stall = 1; flush = 0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    m.scnt = 16'hFFFE;
    chk("stall_cnt_preload", 64'(stall_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) drive(mk(1, 0, 1, 32'h7777_0000 + i, 12'hABC, 0, 12'h000, 0));
    chk("stall_cnt_saturated", 64'(stall_cnt), 64'hFFFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
